// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Sequences issue and writeback on the requester side of the datapath ALU.
// It accepts one operation per valid/ready handshake and holds the operands
// and opcode on the ALU for ALU_LATENCY cycles. It then captures the 64-bit
// result in Z and returns it as one beat, or as two beats (LO then HI) for
// mul/div. Illegal opcodes and divide-by-zero bypass the ALU entirely.
//
// Ports:
//   clk, clr                      clock, async active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_opcode, req_a, req_b      request payload
//   alu_a, alu_b, alu_opcode      registered ALU inputs
//   alu_c                         64-bit ALU result
//   wb_valid/wb_ready             writeback beat handshake
//   wb_data, wb_sel, wb_last      beat payload (sel: 0=LO, 1=HI)
//   wb_err                        operation was illegal or div-by-zero
//   busy                          sequencer not in IDLE
module alu_op_sequencer #(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_opcode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_opcode,
  input  logic [63:0] alu_c,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic        wb_sel,
  output logic        wb_last,
  output logic        wb_err,
  output logic        busy
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  localparam logic [3:0] LAT = 4'(ALU_LATENCY);

  typedef enum logic [1:0] {IDLE, EXEC, WB_LO, WB_HI} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [63:0] z;
  logic        wide;
  logic        err;

  logic        op_legal;
  logic        op_wide;
  logic        op_unary;
  logic        div_zero;

  always_comb begin
    op_legal = 1'b0;
    case (req_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR,
      OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT: op_legal = 1'b1;
      default:                               op_legal = 1'b0;
    endcase
    op_wide  = (req_opcode == OP_MUL) || (req_opcode == OP_DIV);
    op_unary = (req_opcode == OP_NEG) || (req_opcode == OP_NOT);
    div_zero = (req_opcode == OP_DIV) && (req_b == '0);
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      z          <= '0;
      cnt        <= '0;
      wide       <= 1'b0;
      err        <= 1'b0;
      wb_valid   <= 1'b0;
      wb_sel     <= 1'b0;
      wb_last    <= 1'b0;
      wb_err     <= 1'b0;
      wb_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_opcode <= req_opcode;
            alu_a      <= op_unary ? '0 : req_a;
            alu_b      <= req_b;
            cnt        <= LAT;
            if (!op_legal) begin
              z        <= '0;
              err      <= 1'b1;
              wide     <= 1'b0;
              state    <= WB_LO;
              wb_valid <= 1'b1;
              wb_sel   <= 1'b0;
              wb_data  <= '0;
              wb_last  <= 1'b1;
              wb_err   <= 1'b1;
            end else if (div_zero) begin
              // Quotient saturates to all-ones, remainder is the dividend.
              z        <= {req_a, 32'hFFFF_FFFF};
              err      <= 1'b1;
              wide     <= 1'b1;
              state    <= WB_LO;
              wb_valid <= 1'b1;
              wb_sel   <= 1'b0;
              wb_data  <= 32'hFFFF_FFFF;
              wb_last  <= 1'b0;
              wb_err   <= 1'b1;
            end else begin
              err   <= 1'b0;
              wide  <= op_wide;
              state <= EXEC;
            end
          end
        end

        EXEC: begin
          if (cnt != '0) cnt <= cnt - 4'd1;
          // Counter holds 1 during the last of the ALU_LATENCY cycles.
          if (cnt <= 4'd1) begin
            z        <= alu_c;
            state    <= WB_LO;
            wb_valid <= 1'b1;
            wb_sel   <= 1'b0;
            wb_data  <= alu_c[31:0];
            wb_last  <= !wide;
            wb_err   <= err;
          end
        end

        WB_LO: begin
          if (wb_ready) begin
            if (wide) begin
              state   <= WB_HI;
              wb_sel  <= 1'b1;
              wb_data <= z[63:32];
              wb_last <= 1'b1;
            end else begin
              state    <= IDLE;
              wb_valid <= 1'b0;
              wb_sel   <= 1'b0;
              wb_data  <= '0;
              wb_last  <= 1'b0;
              wb_err   <= 1'b0;
            end
          end
        end

        WB_HI: begin
          if (wb_ready) begin
            state    <= IDLE;
            wb_valid <= 1'b0;
            wb_sel   <= 1'b0;
            wb_data  <= '0;
            wb_last  <= 1'b0;
            wb_err   <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Directed bench for alu_op_sequencer. Three instances run with
// ALU_LATENCY = 1, 3 and 4 and share clk/clr. Each instance is driven by a
// small combinational ALU model. Expected beats are hand-computed constants.
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid  [3];
  logic        req_ready  [3];
  logic [4:0]  req_opcode [3];
  logic [31:0] req_a      [3];
  logic [31:0] req_b      [3];
  logic [31:0] alu_a      [3];
  logic [31:0] alu_b      [3];
  logic [4:0]  alu_opcode [3];
  logic [63:0] alu_c      [3];
  logic        wb_valid   [3];
  logic        wb_ready   [3];
  logic [31:0] wb_data    [3];
  logic        wb_sel     [3];
  logic        wb_last    [3];
  logic        wb_err     [3];
  logic        busy       [3];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  function automatic logic [63:0] alu_model(input logic [4:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      5'b00011: return {32'd0, a + b};
      5'b00100: return {32'd0, a - b};
      5'b01111: return 64'(a) * 64'(b);
      5'b10000: return (b == 32'd0) ? 64'd0 : {a % b, a / b};
      5'b10001: return {32'd0, 32'd0 - b};
      5'b10010: return {32'd0, ~b};
      default:  return 64'd0;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    alu_op_sequencer #(.ALU_LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4))) dut (
      .clk        (clk),
      .clr        (clr),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_opcode (req_opcode[g]),
      .req_a      (req_a[g]),
      .req_b      (req_b[g]),
      .alu_a      (alu_a[g]),
      .alu_b      (alu_b[g]),
      .alu_opcode (alu_opcode[g]),
      .alu_c      (alu_c[g]),
      .wb_valid   (wb_valid[g]),
      .wb_ready   (wb_ready[g]),
      .wb_data    (wb_data[g]),
      .wb_sel     (wb_sel[g]),
      .wb_last    (wb_last[g]),
      .wb_err     (wb_err[g]),
      .busy       (busy[g])
    );
    assign alu_c[g] = alu_model(alu_opcode[g], alu_a[g], alu_b[g]);
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One operation on instance d. exp_lat counts cycles from the accept edge
  // to the first cycle with wb_valid. stall holds wb_ready low on the LO beat.
  task automatic do_op(input int d, input string tag, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_alu_a,
                       input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                       input bit exp_wide, input bit exp_err,
                       input int exp_lat, input int stall);
    int c;
    wb_ready[d] = (stall == 0);
    @(negedge clk);
    check({tag, "_ready"}, 64'(req_ready[d]), 64'd1);
    req_valid[d]  = 1'b1;
    req_opcode[d] = op;
    req_a[d]      = a;
    req_b[d]      = b;
    @(negedge clk);
    req_valid[d]  = 1'b0;
    req_a[d]      = ~a;
    req_b[d]      = ~b;
    c = 1;
    check({tag, "_accepted"}, {62'd0, req_ready[d], busy[d]}, 64'd1);
    check({tag, "_alu_in"}, {alu_opcode[d], alu_a[d], alu_b[d]},
          64'({op, exp_alu_a, b}));
    while (!wb_valid[d] && c < 40) begin
      @(negedge clk);
      c++;
      if (!wb_valid[d])
        check({tag, "_alu_hold"}, {alu_a[d], alu_b[d]}, {exp_alu_a, b});
    end
    check({tag, "_lat"}, 64'(c), 64'(exp_lat));
    check({tag, "_lo"}, {28'd0, wb_valid[d], wb_sel[d], wb_last[d], wb_err[d], wb_data[d]},
          {28'd0, 1'b1, 1'b0, !exp_wide, exp_err, exp_lo});
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check({tag, "_lo_hold"}, {28'd0, wb_valid[d], wb_sel[d], wb_last[d], wb_err[d], wb_data[d]},
            {28'd0, 1'b1, 1'b0, !exp_wide, exp_err, exp_lo});
    end
    wb_ready[d] = 1'b1;
    @(negedge clk);
    if (exp_wide) begin
      check({tag, "_hi"}, {28'd0, wb_valid[d], wb_sel[d], wb_last[d], wb_err[d], wb_data[d]},
            {28'd0, 1'b1, 1'b1, 1'b1, exp_err, exp_hi});
      @(negedge clk);
    end
    check({tag, "_done"}, {61'd0, wb_valid[d], req_ready[d], busy[d]}, 64'b010);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_beat;
    for (int i = 0; i < 3; i++) begin
      req_valid[i]  = 1'b0;
      req_opcode[i] = '0;
      req_a[i]      = '0;
      req_b[i]      = '0;
      wb_ready[i]   = 1'b1;
    end
    #3;
    for (int i = 0; i < 3; i += 2)
      check($sformatf("reset_state%0d", i),
            {alu_a[i], wb_data[i]},
            64'd0);
    check("reset_ctl", {50'd0, alu_b[0][7:0], alu_opcode[0], req_ready[0], busy[0], wb_valid[0],
                        wb_sel[0], wb_last[0], wb_err[0]},
          64'b100000);
    @(negedge clk);
    clr = 1'b0;

    // L=1 instance
    do_op(0, "add",     5'b00011, 32'd5, 32'd7, 32'd5,
          32'd12, 32'd0, 1'b0, 1'b0, 2, 0);
    do_op(0, "mul",     5'b01111, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
          32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 2, 3);
    do_op(0, "divz",    5'b10000, 32'd100, 32'd0, 32'd100,
          32'hFFFF_FFFF, 32'h0000_0064, 1'b1, 1'b1, 1, 0);
    do_op(0, "div",     5'b10000, 32'd100, 32'd7, 32'd100,
          32'd14, 32'd2, 1'b1, 1'b0, 2, 0);
    do_op(0, "illegal", 5'b11111, 32'd8, 32'd9, 32'd8,
          32'd0, 32'd0, 1'b0, 1'b1, 1, 0);
    do_op(0, "add2",    5'b00011, 32'd1, 32'd2, 32'd1,
          32'd3, 32'd0, 1'b0, 1'b0, 2, 0);
    do_op(0, "not",     5'b10010, 32'd77, 32'h0F0F_0F0F, 32'd0,
          32'hF0F0_F0F0, 32'd0, 1'b0, 1'b0, 2, 1);

    // L=3 instance
    do_op(1, "neg",     5'b10001, 32'd123, 32'd5, 32'd0,
          32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0, 4, 0);
    do_op(1, "add3",    5'b00011, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF,
          32'd1, 32'd0, 1'b0, 1'b0, 4, 0);

    // L=4 instance: reset in the second EXEC cycle
    wb_ready[2] = 1'b1;
    @(negedge clk);
    req_valid[2]  = 1'b1;
    req_opcode[2] = 5'b00011;
    req_a[2]      = 32'd1;
    req_b[2]      = 32'd1;
    @(negedge clk);
    req_valid[2]  = 1'b0;
    @(negedge clk);
    check("rst_pre_busy", 64'(busy[2]), 64'd1);
    #2 clr = 1'b1;
    #1;
    check("rst_async", {alu_a[2], 20'd0, alu_opcode[2], busy[2], req_ready[2],
                        wb_valid[2], wb_sel[2], wb_last[2], wb_err[2], 1'b0},
          {32'd0, 20'd0, 5'd0, 7'b0100000});
    #1 clr = 1'b0;
    saw_beat = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (wb_valid[2]) saw_beat = 1'b1;
    end
    check("rst_no_beat", 64'(saw_beat), 64'd0);
    do_op(2, "sub",     5'b00100, 32'd9, 32'd4, 32'd9,
          32'd5, 32'd0, 1'b0, 1'b0, 5, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Issue/writeback sequencer on the requester side of the datapath ALU. It accepts one operation request through a valid/ready handshake and drives the ALU operand and opcode inputs for a fixed number of cycles. It then captures the 64-bit ALU result into an internal Z register and returns it to the register file as one or two 32-bit writeback beats (LO, then HI for mul/div). It also intercepts divide-by-zero and illegal opcodes without launching the ALU.

## Interface
- ALU_LATENCY, 1, cycles operands/opcode must be held before `alu_c` is sampled; legal 1–15
- clk  in  1  rising-edge clock
- clr  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept; high only in IDLE
- req_opcode  in  5  operation code
- req_a  in  32  operand A
- req_b  in  32  operand B
- alu_a  out  32  ALU operand A (registered)
- alu_b  out  32  ALU operand B (registered)
- alu_opcode  out  5  ALU opcode (registered)
- alu_c  in  64  ALU result
- wb_valid  out  1  writeback beat present
- wb_ready  in  1  register file accepts beat
- wb_data  out  32  beat data
- wb_sel  out  1  0 = LO/Rd beat, 1 = HI beat
- wb_last  out  1  final beat of operation
- wb_err  out  1  operation was div-by-zero or illegal
- busy  out  1  state != IDLE

## Operation
- Legal opcodes are the following:
  - add 00011, sub 00100, and 00101, or 00110
  - shr 00111, shra 01000, shl 01001, ror 01010, rol 01011
  - mul 01111, div 10000, neg 10001, not 10010
- Wide ops are mul and div. Unary ops are neg and not.
- The state machine has four states: IDLE, EXEC, WB_LO, WB_HI.
- IDLE: req_ready=1. On req_valid:
  - Latch opcode into alu_opcode.
  - Latch req_a into alu_a; unary ops latch 0 into alu_a instead.
  - Latch req_b into alu_b.
  - Latch wide/err flags.
  - Load the latency counter with ALU_LATENCY.
- Next state from IDLE after accept:
  - Illegal opcode: z ← 0, err=1, wide=0, go to WB_LO.
  - div with req_b==0: z ← {req_a, 32'hFFFFFFFF}, err=1, wide=1, go to WB_LO. The ALU is not waited on.
  - Otherwise: go to EXEC.
- EXEC: the counter decrements each cycle. On the cycle the counter reaches 1, capture z ← alu_c and go to WB_LO. EXEC lasts exactly ALU_LATENCY cycles.
- WB_LO drives wb_valid=1, wb_sel=0, wb_data=z[31:0], wb_last=!wide, wb_err=err.
  - On wb_ready: go to WB_HI if wide, else IDLE.
- WB_HI drives wb_valid=1, wb_sel=1, wb_data=z[63:32], wb_last=1, wb_err=err.
  - On wb_ready: go to IDLE.
- Non-wide ops ignore z[63:32].
- alu_a, alu_b and alu_opcode hold their values from accept until the next accept, including through WB and IDLE.

## Timing
- Reset (clr=1, asynchronous) sets:
  - state=IDLE
  - alu_a=0, alu_b=0, alu_opcode=0, z=0, counter=0, flags=0
  - wb_valid=0, wb_sel=0, wb_last=0, wb_err=0, wb_data=0
  - busy=0, req_ready=1
- Accept occurs at edge E where req_valid&req_ready=1.
  - Normal op: EXEC spans cycles E+1..E+L. wb_valid first rises in cycle E+L+1.
  - Err op: wb_valid rises in cycle E+1.
- While wb_valid=1 and wb_ready=0, wb_data, wb_sel, wb_last and wb_err are stable.
- The LO beat always precedes the HI beat. There are never two beats in one cycle.
- req_ready is 0 from the cycle after accept until the cycle after the final wb handshake.
  - Minimum spacing for a non-wide op with L=1 and wb_ready tied high is 3 cycles per op.
- req_* inputs are ignored outside IDLE.
- wb_ready is ignored when wb_valid=0.
- clr mid-operation aborts immediately. No further beats are emitted and no partial HI beat follows.
- The counter never wraps. ALU_LATENCY=1 gives exactly one EXEC cycle.

## Test plan
- **add, single beat:** ALU_LATENCY=1, wb_ready=1; add a=5 b=7.
  -> wb_valid in cycle E+2, wb_data=12, wb_sel=0, wb_last=1, wb_err=0; req_ready high again in E+3.
- **mul, two beats with backpressure:** mul a=0x00010000 b=0x00010000, wb_ready low for 3 cycles during LO.
  -> LO beat 0x00000000 held stable, then HI beat 0x00000001 with wb_last=1.
- **div by zero:** div a=100 b=0.
  -> wb_valid in E+1, beats 0xFFFFFFFF then 0x00000064, wb_err=1 on both, no EXEC cycles.
- **neg, unary operand:** neg a=123 b=5, L=3.
  -> alu_a=0 and alu_b=5 for cycles E+1..E+3, single beat 0xFFFFFFFB.
- **illegal opcode:** opcode 11111.
  -> single beat wb_data=0, wb_err=1, wb_last=1; next add request completes normally.
- **reset mid-operation:** ALU_LATENCY=4, clr pulsed in second EXEC cycle.
  -> outputs reset asynchronously, no beat emitted; subsequent sub a=9 b=4 returns 5.
